hazard_unit: RTL and testbench
==============================

# hazard_unit

Scoreboard-based hazard and forwarding controller for the five-stage pipeline; successor to the purely combinational decode controller, adding a stage-tracked Tnew pipeline and a multiply/divide busy counter. It sits beside the D stage, takes the decoded Tuse/Tnew/destination of the instruction in D, and tracks in-flight writers in E, M and W. Every cycle it produces the F/D stall, the E-stage bubble and the D-stage forwarding selects.

## Interface
- `REG_AW`, 5: register address width.
- `T_W`, 3: width of Tuse/Tnew fields.
- `MULT_CYC`, 5: mult/multu busy cycles.
- `DIV_CYC`, 10: div/divu busy cycles.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `d_valid` in 1: D holds a real instruction; 0 means bubble.
- `d_rs`, `d_rt` in REG_AW: source registers of the D instruction.
- `d_tuse_rs`, `d_tuse_rt` in T_W: cycles until the operand is needed; 3 means unused.
- `d_wr_en` in 1: D instruction writes the GPR file.
- `d_wr_addr` in REG_AW: destination register.
- `d_tnew` in T_W: cycles after entering E until the result exists (calc=1, load=2, jal/lui=0).
- `d_is_md` in 1: mult/div/mfhi/mflo/mthi/mtlo.
- `d_md_start` in 1: instruction starts the MDU.
- `d_md_div` in 1: started operation is a divide.
- `stall` out 1: hold PC and the F/D register.
- `e_bubble` out 1: load a NOP into the D/E register; equals `stall`.
- `fwd_rs_sel`, `fwd_rt_sel` out 2: D operand source; 0 = GPR file, 1 = E, 2 = M, 3 = W.
- `md_busy` out 1: MDU counter is nonzero.

## Operation
- The scoreboard has three entries (E, M, W), each holding {valid, wr_en, addr, tnew}.
- A match at stage s for source r requires all of: valid, wr_en, addr == r, r != 0.
- Only the youngest match counts, in priority order E > M > W.
- Data stall for rs:
  - d_valid, and the youngest match has tnew > d_tuse_rs.
  - rt is checked the same way with d_tuse_rt.
- MD stall: d_valid & d_is_md & md_busy.
- stall = rs stall | rt stall | MD stall.
- Forward select for rs:
  - Set to the stage code of the youngest match if that match has tnew == 0; otherwise 0.
  - rt works the same way.
  - A youngest match with 0 < tnew <= tuse gives select 0 and no stall; forwarding for it happens in a later stage.
- Advance on every edge; downstream stages never stall.
  - W <= M and M <= E, each with tnew' = (tnew == 0) ? 0 : tnew-1.
  - E <= D with tnew = d_tnew when d_valid & !stall; otherwise E is cleared (valid = 0).
- MDU counter (width sized for max(MULT_CYC, DIV_CYC)):
  - When D enters E with d_md_start, the counter loads DIV_CYC if d_md_div, else MULT_CYC.
  - Otherwise it decrements when nonzero.
  - md_busy = (cnt != 0).
  - A start is only accepted when not stalled, so a load never collides with a nonzero count.

## Timing
- Reset: all entries invalid, cnt = 0. Outputs after reset: stall = 0, e_bubble = 0, fwd selects = 0, md_busy = 0.
- Reset asserted mid-MDU operation or mid-stall clears everything at that edge.
- stall and fwd selects are combinational from the current D inputs and the registered scoreboard, with zero-cycle latency. md_busy is a registered decode.
- Stall duration for a single producer is exactly tnew - tuse cycles.
- An MDU start followed by a dependent md instruction stalls that instruction for exactly N cycles (N = MULT_CYC or DIV_CYC).
- Simultaneous data stall and MD stall produce a single stall; the E entry is still cleared.
- d_valid = 0 never stalls and never enters the scoreboard.
- Writes to $0 never stall or forward.
- Saturation: tnew never wraps below 0.

## Test plan
- Load-use:
  - Stimulus: lw $1 (tnew 2) followed by add $2,$1,$3 (tuse_rs 1).
  - Required: stall = 1 for one cycle, E bubbled, then stall = 0 with fwd_rs_sel = 0.
- Branch after calc:
  - Stimulus: add $4 (tnew 1) followed by beq $4,$0 (tuse 0).
  - Required: stall for one cycle, then fwd_rs_sel = 2 (M).
- Youngest wins:
  - Stimulus: ori $5 (tnew 1), add $6, then jal (tnew 0) writing $5; D jr $5 (tuse 0).
  - Required: fwd_rs_sel = 1 (E); no stall.
- $0 and bubble:
  - Stimulus: add $0 followed by beq $0.
  - Required: no stall and fwd_rs_sel = 0. With d_valid = 0 and a matching hazard present, stall = 0.
- MDU:
  - Stimulus: div (DIV_CYC 10) followed by mflo.
  - Required: md_busy high for 10 cycles, stall for 10 cycles, mflo issues on the cycle md_busy falls.
  - Also: a mult followed by a non-md add shows no stall.
- Reset mid-operation:
  - Stimulus: assert reset at cnt = 4 during a lw stall.
  - Required: the next cycle shows stall = 0, md_busy = 0, and all selects = 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: scoreboard-based stall, bubble and D-stage forwarding control with an MDU busy counter
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int T_W      = 3,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic              d_wr_en,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [T_W-1:0]    d_tnew,
    input  logic              d_is_md,
    input  logic              d_md_start,
    input  logic              d_md_div,
    output logic              stall,
    output logic              e_bubble,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              md_busy
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] a;
        logic [T_W-1:0]    t;
    } ent_t;

    ent_t e_q, m_q, w_q, e_d, m_d, w_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] rs_stg, rt_stg;
    logic [T_W-1:0] rs_t, rt_t;
    logic accept;

    function automatic logic hit(input ent_t x, input logic [REG_AW-1:0] r);
        return x.v && x.we && x.a == r && r != '0;
    endfunction

    function automatic logic [1:0] youngest(input ent_t e, input ent_t m, input ent_t w,
                                            input logic [REG_AW-1:0] r);
        return hit(e, r) ? 2'd1 : hit(m, r) ? 2'd2 : hit(w, r) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [T_W-1:0] tnew_of(input ent_t e, input ent_t m, input ent_t w,
                                               input logic [1:0] s);
        return (s == 2'd1) ? e.t : (s == 2'd2) ? m.t : w.t;
    endfunction

    function automatic ent_t age(input ent_t x);
        age   = x;
        age.t = (x.t == '0) ? '0 : x.t - 1'b1;
    endfunction

    // hazard detection, forwarding selects and scoreboard/counter next state
    always_comb begin
        rs_stg     = youngest(e_q, m_q, w_q, d_rs);
        rt_stg     = youngest(e_q, m_q, w_q, d_rt);
        rs_t       = tnew_of(e_q, m_q, w_q, rs_stg);
        rt_t       = tnew_of(e_q, m_q, w_q, rt_stg);
        md_busy    = cnt_q != '0;
        stall      = d_valid && ((rs_stg != 2'd0 && rs_t > d_tuse_rs) ||
                                 (rt_stg != 2'd0 && rt_t > d_tuse_rt) ||
                                 (d_is_md && md_busy));
        e_bubble   = stall;
        fwd_rs_sel = (rs_t == '0) ? rs_stg : 2'd0;
        fwd_rt_sel = (rt_t == '0) ? rt_stg : 2'd0;
        accept     = d_valid && !stall;
        w_d        = age(m_q);
        m_d        = age(e_q);
        e_d        = accept ? {1'b1, d_wr_en, d_wr_addr, d_tnew} : '0;
        cnt_d      = (accept && d_md_start) ? (d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC)) :
                     md_busy ? cnt_q - 1'b1 : cnt_q;
    end

    // pipeline the scoreboard and MDU counter every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard-driven directed test of hazard_unit
module tb_hazard_unit;
    logic clk = 0, reset = 1;
    logic d_valid = 0, d_wr_en = 0, d_is_md = 0, d_md_start = 0, d_md_div = 0;
    logic [4:0] d_rs = 0, d_rt = 0, d_wr_addr = 0;
    logic [2:0] d_tuse_rs = 3, d_tuse_rt = 3, d_tnew = 0;
    logic stall, e_bubble, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    int n_checks = 0, n_pass = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] fs;
        logic [1:0] ft;
        logic       busy;
    } exp_t;
    exp_t exp_q[$];

    hazard_unit dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr_en(d_wr_en),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_is_md(d_is_md),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .stall(stall),
        .e_bubble(e_bubble), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic compare();
        exp_t x;
        x = exp_q.pop_front();
        check({x.tag, ".stall"}, stall, x.stall);
        check({x.tag, ".bubble"}, e_bubble, x.stall);
        check({x.tag, ".fwd_rs"}, fwd_rs_sel, x.fs);
        check({x.tag, ".fwd_rt"}, fwd_rt_sel, x.ft);
        check({x.tag, ".busy"}, md_busy, x.busy);
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [2:0] urs, input logic [2:0] urt, input logic we,
                        input logic [4:0] wa, input logic [2:0] tn, input logic md,
                        input logic ms, input logic mdiv, input logic es,
                        input logic [1:0] efs, input logic [1:0] eft, input logic eb);
        @(negedge clk);
        reset = 0;
        d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
        d_wr_en = we; d_wr_addr = wa; d_tnew = tn; d_is_md = md; d_md_start = ms; d_md_div = mdiv;
        exp_q.push_back('{tag, es, efs, eft, eb});
        #2 compare();
    endtask

    task automatic nops(input int n, input logic eb);
        for (int i = 0; i < n; i++) step("nop", 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, eb);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back('{"reset", 0, 0, 0, 0});
        #2 compare();

        step("lw1", 1, 0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step("lu_stall", 1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0);
        step("lu_go", 1, 1, 3, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        nops(3, 0);

        step("add4", 1, 0, 0, 3, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        step("beq_stall", 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("beq_fwd_m", 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        nops(3, 0);

        step("ori5", 1, 0, 0, 3, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("add6", 1, 0, 0, 3, 3, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        step("jal5", 1, 0, 0, 3, 3, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        step("jr_fwd_e", 1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rt_fwd_m", 1, 0, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        nops(3, 0);

        step("add0", 1, 0, 0, 3, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("beq0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nops(3, 0);
        step("lw7", 1, 0, 0, 3, 3, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0);
        step("bubble_dep", 0, 7, 0, 0, 3, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0);
        step("dep_m_stall", 1, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("dep_w_fwd", 1, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        nops(3, 0);

        step("div", 1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            step("mflo_wait", 1, 0, 0, 3, 3, 1, 8, 1, 1, 0, 0, 1, 0, 0, 1);
        step("mflo_go", 1, 0, 0, 3, 3, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
        nops(3, 0);

        step("mult", 1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("add_nomd", 1, 0, 0, 3, 3, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        nops(4, 1);
        nops(3, 0);

        step("mult_r", 1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("lw1_r", 1, 0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
        step("lu_stall_r", 1, 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0, 1);
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back('{"after_reset", 0, 0, 0, 0});
        #2 compare();
        step("post_reset", 1, 1, 1, 1, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);

        if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
